// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - saturating batch accumulator for multiplier products
module product_accumulator #(
    parameter int n         = 6,
    parameter int acc_width = 12,
    parameter int count_len = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [n-1:0]         c,
    input  logic                 flush,
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [acc_width-1:0] sum,
    output logic [7:0]           count,
    output logic                 sat
);

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic [acc_width-1:0] acc_max = '1;

    state_t               state;
    state_t               state_next;
    logic [acc_width-1:0] acc;
    logic [acc_width-1:0] acc_next;
    logic [7:0]           cnt;
    logic [7:0]           cnt_next;
    logic                 sat_r;
    logic                 sat_next;

    logic                 recv_fire;
    logic                 send_fire;
    logic [acc_width:0]   add_full;
    logic [7:0]           cnt_inc;
    logic                 batch_full;

    // Handshake outputs come only from the state register, gated off while reset is high.
    assign recv_rdy = !reset && (state == ACC);
    assign send_val = !reset && (state == DONE);

    assign recv_fire = recv_val && recv_rdy;
    assign send_fire = send_val && send_rdy;

    // One extra bit on the adder exposes overflow of the unsigned sum.
    assign add_full   = {1'b0, acc} + {{(acc_width + 1 - n){1'b0}}, c};
    assign cnt_inc    = cnt + 8'd1;
    assign batch_full = (cnt_inc == 8'(count_len));

    assign sum   = acc;
    assign count = cnt;
    assign sat   = sat_r;

    // State and datapath registers; reset discards any batch in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            sat_r <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            sat_r <= sat_next;
        end
    end

    // Next-state: accumulate with saturation in ACC, present and clear in DONE.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        sat_next   = sat_r;
        case (state)
            ACC: begin
                if (recv_fire) begin
                    acc_next = add_full[acc_width] ? acc_max : add_full[acc_width-1:0];
                    sat_next = sat_r | add_full[acc_width];
                    cnt_next = cnt_inc;
                    if (batch_full || flush) begin
                        state_next = DONE;
                    end
                end else if (flush && (cnt != 8'd0)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (send_fire) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    sat_next   = 1'b0;
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream stage of the iterative fixed-point multiplier: it consumes unsigned products over a val/rdy handshake and sums a batch of `count_len` products. It presents the saturated sum, the batch element count and a saturation flag on an output val/rdy port. It lets the pin-limited top level return multiply-accumulate results without extra host-side adds.

## Interface
- `n`, 6: width of each incoming product (matches multiplier `n`; unsigned, `d` = 0).
- `acc_width`, 12: width of the sum register; must be >= `n`.
- `count_len`, 4: products per full batch; legal range 1..255.
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- `recv_val`  in  1  product valid from multiplier `send_val`.
- `recv_rdy`  out  1  block can accept a product; drives multiplier `send_rdy`.
- `c`  in  `n`  product from multiplier `c`.
- `flush`  in  1  close the current batch early with a partial sum.
- `send_val`  out  1  sum valid.
- `send_rdy`  in  1  consumer ready.
- `sum`  out  `acc_width`  accumulated sum.
- `count`  out  8  number of products in the presented sum.
- `sat`  out  1  sum saturated during this batch.

## Operation
- Two states: ACC (collecting) and DONE (presenting).
- Registers: `acc` (`acc_width`), `cnt` (8), `sat_r` (1), `state`.
- Reset (asserted, async): state=ACC, acc=0, cnt=0, sat_r=0. While reset is high, `recv_rdy`=0 and `send_val`=0, even though state=ACC.
- In ACC, `recv_rdy`=1 and `send_val`=0.
  - Receive fire (`recv_val` & `recv_rdy`):
    - acc <= acc + zero-extend(c).
    - If the true sum exceeds 2^`acc_width`-1: acc <= 2^`acc_width`-1 and sat_r <= 1.
    - cnt <= cnt+1.
  - If the fire makes cnt+1 == `count_len`, go to DONE in the same edge. The last product is included.
  - `flush`=1 in ACC:
    - With a fire in the same cycle: the product is accumulated first, then state goes to DONE.
    - Without a fire and cnt>0: go to DONE with the current acc/cnt.
    - Without a fire and cnt==0: ignored, stay in ACC.
- In DONE, `recv_rdy`=0, `send_val`=1, and `sum`=acc, `count`=cnt, `sat`=sat_r are held stable.
  - `flush` is ignored.
  - Send fire (`send_val` & `send_rdy`): acc<=0, cnt<=0, sat_r<=0, go to ACC.
- `sum`/`count`/`sat` are driven directly from the registers in every state and are only meaningful when `send_val`=1.
- `c` is sampled only on a receive fire. Its value at any other time has no effect.
- Saturation is checked per addition. Once saturated, acc stays at max for the rest of the batch.

## Timing
- `recv_rdy` and `send_val` are decoded from the state register plus the `reset` gate. There is no combinational path from `recv_val`, `send_rdy` or `flush` to any output.
- Latency: the last product is accepted on edge t; `send_val`=1 from edge t to the edge where the send fire occurs.
- After a send fire on edge t, `recv_rdy`=1 from edge t. There is one bubble cycle per batch: the block never receives and sends in the same cycle.
- Back-to-back receive fires are accepted every cycle in ACC. Throughput is `count_len` products per `count_len`+1 cycles with `send_rdy` held high.
- Reset asserted mid-batch or in DONE: the state is discarded immediately and the pending sum is lost; `send_val` drops asynchronously.
- `count_len`=1: every accepted product goes straight to DONE.

## Test plan
- Reset then full batch: `count_len`=4, products 3,5,7,9 on consecutive cycles, `send_rdy`=1 -> `send_val` on the cycle after the 4th fire, `sum`=24, `count`=4, `sat`=0, then `recv_rdy`=1 on the next cycle.
- Backpressure: same batch with `send_rdy`=0 for 5 cycles -> `send_val` held 1, `sum`=24 stable, `recv_rdy`=0 throughout, `recv_val`=1 with `c`=63 not absorbed. Release `send_rdy` -> next batch starts from 0.
- Saturation: `acc_width`=7, `count_len`=4, products 63,63,63,1 -> `sum`=127, `sat`=1, `count`=4. The next batch of 1,1,1,1 -> `sum`=4, `sat`=0.
- Flush variants:
  - 10,20 then `flush` alone -> `sum`=30, `count`=2.
  - `flush` with cnt=0 and no fire -> no `send_val`.
  - `flush` together with a fire of 5 after 10 -> `sum`=15, `count`=2.
- Reset mid-operation: two products accepted, then `reset` pulsed asynchronously between edges -> `recv_rdy`/`send_val` = 0 during reset. After release, batch 1,1,1,1 gives `sum`=4, `count`=4.
- Randomized `recv_val`/`send_rdy` with a scoreboard model over 1000 products, `count_len`=3 -> every `sum` matches the reference saturating sum, and no product is lost or duplicated.
